// File: rtl/mac_reg_responder_pkg.sv
// Shared constants for the MAC register responder: register map, reset defaults,
// command_config bit positions and the access FSM state encoding.
package mac_resp_pkg;

  localparam logic [9:0] ADDR_REV     = 10'h000;
  localparam logic [9:0] ADDR_SCRATCH = 10'h001;
  localparam logic [9:0] ADDR_CMD     = 10'h002;
  localparam logic [9:0] ADDR_MAC0    = 10'h003;
  localparam logic [9:0] ADDR_MAC1    = 10'h004;
  localparam logic [9:0] ADDR_FRM_LEN = 10'h005;
  localparam logic [9:0] ADDR_STAT_RD = 10'h03A;
  localparam logic [9:0] ADDR_STAT_WR = 10'h03B;

  localparam logic [31:0] CMD_DEFAULT     = 32'h0000_0000;
  localparam logic [31:0] SCRATCH_DEFAULT = 32'h0000_0000;
  localparam logic [15:0] FRM_LEN_DEFAULT = 16'd1518;

  localparam int CMD_TX_ENA_BIT   = 0;
  localparam int CMD_RX_ENA_BIT   = 1;
  localparam int CMD_SW_RESET_BIT = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_reg_responder_if.sv
// Avalon-MM style register bus between an initiator (master) and the responder (slave).
interface mac_reg_responder_if;
  logic [9:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        RD;
  logic        WR;
  logic        BUSY;

  modport master (output ADR_I, output DAT_I, output RD, output WR,
                  input  DAT_O, input  BUSY);
  modport slave  (input  ADR_I, input  DAT_I, input  RD, input  WR,
                  output DAT_O, output BUSY);
endinterface

// File: rtl/mac_reg_responder_regfile.sv
// Register storage, read decode and self-clearing SW_RESET for the MAC responder.
// Optional read-only access counters are built when MAC_RESP_STATS_EN is defined.
module mac_resp_regfile
  import mac_resp_pkg::*;
#(
  parameter logic [31:0] REV_ID          = 32'h0000_0901,
  parameter int          SW_RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_commit,
`ifdef MAC_RESP_STATS_EN
  input  logic        i_rd_commit,
`endif
  input  logic [9:0]  i_adr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        tx_ena,
  output logic        rx_ena,
  output logic        sw_reset_active,
  output logic [47:0] mac_addr
);

  localparam logic [7:0] LP_SWR_LOAD = 8'(SW_RESET_CYCLES);

  logic [31:0] r_scratch, r_cmd, r_mac0;
  logic [15:0] r_mac1, r_frm_len;
  logic [7:0]  r_swr_cnt;
  logic [31:0] w_cmd_next;
  logic [7:0]  w_swr_cnt_next;
  logic        w_cmd_wr;

  assign w_cmd_wr = i_wr_commit && (i_adr == ADDR_CMD);

  // While SW_RESET runs, writes may change other bits but bit 13 belongs to the counter.
  always_comb begin
    w_cmd_next     = r_cmd;
    w_swr_cnt_next = r_swr_cnt;
    if (w_cmd_wr) begin
      w_cmd_next = i_wdata;
    end else begin
      w_cmd_next = r_cmd;
    end
    if (r_cmd[CMD_SW_RESET_BIT]) begin
      if (r_swr_cnt <= 8'd1) begin
        w_cmd_next[CMD_SW_RESET_BIT] = 1'b0;
        w_swr_cnt_next               = 8'd0;
      end else begin
        w_cmd_next[CMD_SW_RESET_BIT] = 1'b1;
        w_swr_cnt_next               = r_swr_cnt - 8'd1;
      end
    end else if (w_cmd_wr && i_wdata[CMD_SW_RESET_BIT]) begin
      w_swr_cnt_next = LP_SWR_LOAD;
    end else begin
      w_swr_cnt_next = r_swr_cnt;
    end
  end

  // Register storage; writes land on the ACK edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scratch <= SCRATCH_DEFAULT;
      r_cmd     <= CMD_DEFAULT;
      r_mac0    <= 32'h0000_0000;
      r_mac1    <= 16'h0000;
      r_frm_len <= FRM_LEN_DEFAULT;
      r_swr_cnt <= 8'd0;
    end else begin
      r_cmd     <= w_cmd_next;
      r_swr_cnt <= w_swr_cnt_next;
      if (i_wr_commit) begin
        case (i_adr)
          ADDR_SCRATCH: r_scratch <= i_wdata;
          ADDR_MAC0:    r_mac0    <= i_wdata;
          ADDR_MAC1:    r_mac1    <= i_wdata[15:0];
          ADDR_FRM_LEN: r_frm_len <= i_wdata[15:0];
          default:      r_scratch <= r_scratch;
        endcase
      end
    end
  end

`ifdef MAC_RESP_STATS_EN
  logic [31:0] r_stat_rd, r_stat_wr;

  // Completed-access counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_rd <= 32'd0;
      r_stat_wr <= 32'd0;
    end else begin
      if (i_rd_commit) r_stat_rd <= r_stat_rd + 32'd1;
      if (i_wr_commit) r_stat_wr <= r_stat_wr + 32'd1;
    end
  end
`endif

  // Read decode; unmapped addresses return zero.
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_adr)
      ADDR_REV:     o_rdata = REV_ID;
      ADDR_SCRATCH: o_rdata = r_scratch;
      ADDR_CMD:     o_rdata = r_cmd;
      ADDR_MAC0:    o_rdata = r_mac0;
      ADDR_MAC1:    o_rdata = {16'h0000, r_mac1};
      ADDR_FRM_LEN: o_rdata = {16'h0000, r_frm_len};
`ifdef MAC_RESP_STATS_EN
      ADDR_STAT_RD: o_rdata = r_stat_rd;
      ADDR_STAT_WR: o_rdata = r_stat_wr;
`endif
      default:      o_rdata = 32'h0000_0000;
    endcase
  end

  assign sw_reset_active = r_cmd[CMD_SW_RESET_BIT];
  assign tx_ena          = r_cmd[CMD_TX_ENA_BIT] & ~r_cmd[CMD_SW_RESET_BIT];
  assign rx_ena          = r_cmd[CMD_RX_ENA_BIT] & ~r_cmd[CMD_SW_RESET_BIT];
  assign mac_addr        = {r_mac1, r_mac0};

endmodule

// File: rtl/mac_reg_responder.sv
// MAC register responder top: access FSM with programmable wait states and BUSY.
// Optional access statistics are enabled with MAC_RESP_STATS_EN.
module mac_reg_responder
  import mac_resp_pkg::*;
#(
  parameter int          WAIT_CYCLES     = 2,
  parameter logic [31:0] REV_ID          = 32'h0000_0901,
  parameter int          SW_RESET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_reg_responder_if.slave   bus,
  output logic                 tx_ena,
  output logic                 rx_ena,
  output logic [47:0]          mac_addr,
  output logic                 sw_reset_active
);

  localparam logic [3:0] LP_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_dat_o;
  logic [31:0] w_rd_data;
  logic        w_req;
  logic        w_wr_commit;

  assign w_req       = bus.RD | bus.WR;
  assign w_wr_commit = (r_state == ST_ACK) && bus.WR;
  // Reset gating keeps BUSY low the instant an access is killed by reset.
  assign bus.BUSY    = reset & w_req & (r_state != ST_ACK);
  assign bus.DAT_O   = r_dat_o;

`ifdef MAC_RESP_STATS_EN
  logic w_rd_commit;
  assign w_rd_commit = (r_state == ST_ACK) && bus.RD && !bus.WR;
`endif

  // Access FSM; read data is captured on entry to ACK and cleared on exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_dat_o    <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dat_o <= 32'h0000_0000;
          if (w_req) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= LP_WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt <= 4'd1) begin
            r_state    <= ST_ACK;
            r_wait_cnt <= 4'd0;
            r_dat_o    <= bus.WR ? 32'h0000_0000 : w_rd_data;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_dat_o <= 32'h0000_0000;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 4'd0;
          r_dat_o    <= 32'h0000_0000;
        end
      endcase
    end
  end

  mac_resp_regfile #(
    .REV_ID          (REV_ID),
    .SW_RESET_CYCLES (SW_RESET_CYCLES)
  ) u_regfile (
    .clk             (clk),
    .reset           (reset),
    .i_wr_commit     (w_wr_commit),
`ifdef MAC_RESP_STATS_EN
    .i_rd_commit     (w_rd_commit),
`endif
    .i_adr           (bus.ADR_I),
    .i_wdata         (bus.DAT_I),
    .o_rdata         (w_rd_data),
    .tx_ena          (tx_ena),
    .rx_ena          (rx_ena),
    .sw_reset_active (sw_reset_active),
    .mac_addr        (mac_addr)
  );

endmodule

// File: tb/tb_mac_reg_responder.sv
// Directed bench for mac_reg_responder with default parameters.
module tb_mac_reg_responder;
  import mac_resp_pkg::*;

  logic        clk;
  logic        reset;
  logic        tx_ena, rx_ena, sw_reset_active;
  logic [47:0] mac_addr;
  int          errors;
  int          checks;
  logic [31:0] rdata;
  int          busy_n;
  logic [31:0] stat_before;

  mac_reg_responder_if bus ();

  mac_reg_responder dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .tx_ena          (tx_ena),
    .rx_ena          (rx_ena),
    .mac_addr        (mac_addr),
    .sw_reset_active (sw_reset_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; returns data seen in the non-busy cycle and the busy cycle count.
  task automatic access(input logic rd, input logic wr, input logic [9:0] adr,
                        input logic [31:0] dat, output logic [31:0] d, output int nbusy);
    bit done;
    done  = 1'b0;
    nbusy = 0;
    d     = 32'h0;
    bus.ADR_I = adr;
    bus.DAT_I = dat;
    bus.RD    = rd;
    bus.WR    = wr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.BUSY) nbusy++;
      else begin
        d    = bus.DAT_O;
        done = 1'b1;
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL access_timeout observed=busy expected=ack adr=%h", adr);
    end
    @(posedge clk);
    #1;
    bus.RD = 1'b0;
    bus.WR = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.ADR_I = 10'h000;
    bus.DAT_I = 32'h0;
    bus.RD    = 1'b0;
    bus.WR    = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {47'h0, bus.BUSY}, 48'h0);
    check("rst_dat_o", {16'h0, bus.DAT_O}, 48'h0);
    check("rst_mac",   mac_addr, 48'h0);
    check("rst_ctrl",  {45'h0, tx_ena, rx_ena, sw_reset_active}, 48'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, ADDR_REV, 32'h0, rdata, busy_n);
    check("rev_busy_cycles", 48'(busy_n), 48'd2);
    check("rev_data", {16'h0, rdata}, 48'h0000_0000_0901);
    @(negedge clk);
    check("dat_o_idle", {16'h0, bus.DAT_O}, 48'h0);

    access(1'b1, 1'b0, ADDR_FRM_LEN, 32'h0, rdata, busy_n);
    check("frm_len_default", {16'h0, rdata}, 48'h0000_0000_05EE);
    access(1'b1, 1'b0, ADDR_CMD, 32'h0, rdata, busy_n);
    check("cmd_default", {16'h0, rdata}, 48'h0);

    access(1'b0, 1'b1, ADDR_REV, 32'hDEAD_BEEF, rdata, busy_n);
    access(1'b1, 1'b0, ADDR_REV, 32'h0, rdata, busy_n);
    check("rev_ro", {16'h0, rdata}, 48'h0000_0000_0901);
    access(1'b0, 1'b1, 10'h010, 32'h1234_5678, rdata, busy_n);
    access(1'b1, 1'b0, 10'h010, 32'h0, rdata, busy_n);
    check("unmapped_rd", {16'h0, rdata}, 48'h0);

    access(1'b0, 1'b1, ADDR_MAC0, 32'h1122_3344, rdata, busy_n);
    access(1'b0, 1'b1, ADDR_MAC1, 32'hFFFF_5566, rdata, busy_n);
    check("mac_addr", mac_addr, 48'h5566_1122_3344);
    access(1'b1, 1'b0, ADDR_MAC1, 32'h0, rdata, busy_n);
    check("mac1_rd", {16'h0, rdata}, 48'h0000_0000_5566);

    // SW_RESET: bit 13 held for four cycles, enables masked meanwhile.
    access(1'b0, 1'b1, ADDR_CMD, 32'h0000_2003, rdata, busy_n);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("swr_active", {45'h0, sw_reset_active, tx_ena, rx_ena}, 48'h4);
    end
    @(negedge clk);
    check("swr_done", {45'h0, sw_reset_active, tx_ena, rx_ena}, 48'h3);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, ADDR_CMD, 32'h0, rdata, busy_n);
    check("cmd_after_swr", {16'h0, rdata}, 48'h0000_0000_0003);

    access(1'b1, 1'b0, ADDR_STAT_RD, 32'h0, stat_before, busy_n);
    // Abort: RD dropped after one busy cycle.
    bus.ADR_I = ADDR_REV;
    bus.RD    = 1'b1;
    @(negedge clk);
    check("abort_busy", {47'h0, bus.BUSY}, 48'h1);
    @(posedge clk);
    #1;
    bus.RD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_ack", {16'h0, bus.DAT_O}, 48'h0);
    end
    check("abort_idle", {46'h0, dut.r_state}, {46'h0, ST_IDLE});
    access(1'b1, 1'b0, ADDR_STAT_RD, 32'h0, rdata, busy_n);
`ifdef MAC_RESP_STATS_EN
    check("stat_rd_abort", {16'h0, rdata}, {16'h0, stat_before + 32'd1});
`else
    check("stat_rd_unmapped", {16'h0, rdata}, 48'h0);
`endif

    access(1'b1, 1'b1, ADDR_SCRATCH, 32'hA5A5_A5A5, rdata, busy_n);
    check("rdwr_dat_o", {16'h0, rdata}, 48'h0);
    access(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, rdata, busy_n);
    check("rdwr_scratch", {16'h0, rdata}, 48'h0000_A5A5_A5A5);

    // Reset in the middle of a write.
    bus.ADR_I = ADDR_SCRATCH;
    bus.DAT_I = 32'h1234_5678;
    bus.WR    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {47'h0, bus.BUSY}, 48'h0);
    bus.WR = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, rdata, busy_n);
    check("rst_mid_scratch", {16'h0, rdata}, 48'h0);

    // Back-to-back: second request raised immediately after the first completes.
    access(1'b0, 1'b1, ADDR_SCRATCH, 32'h0BAD_F00D, rdata, busy_n);
    access(1'b1, 1'b0, ADDR_SCRATCH, 32'h0, rdata, busy_n);
    check("b2b_busy_cycles", 48'(busy_n), 48'd2);
    check("b2b_data", {16'h0, rdata}, 48'h0000_0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_reg_responder.md
MAC_REG_RESPONDER -- requirements
Module: mac_reg_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of BUSY cycles inserted before each access completes (legal range 1..15).
REQ-002 Parameter REV_ID, default 32'h0000_0901, SHALL set the read-only revision register value.
REQ-003 Parameter SW_RESET_CYCLES, default 4, SHALL set the number of cycles the SW_RESET bit stays set before self-clearing (legal range 1..255).
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ADR_I  input  10  word address from the Avalon-MM initiator.
REQ-007 DAT_I  input  32  write data from the initiator.
REQ-008 DAT_O  output  32  read data to the initiator.
REQ-009 RD  input  1  read request, held high by the initiator until BUSY is low.
REQ-010 WR  input  1  write request, held high by the initiator until BUSY is low.
REQ-011 BUSY  output  1  waitrequest to the initiator.
REQ-012 tx_ena, rx_ena  output  1 each  command_config bits 0 and 1, forced low while SW_RESET is set.
REQ-013 mac_addr  output  48  {mac_1[15:0], mac_0[31:0]}.
REQ-014 sw_reset_active  output  1  high while command_config bit 13 is set.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-016 IDLE -> WAIT when RD or WR is high; the wait counter SHALL load WAIT_CYCLES-1.
REQ-017 WAIT SHALL decrement the counter each cycle and go to ACK when it reaches 0; if RD and WR are both low, it SHALL go to IDLE with no side effect (abort).
REQ-018 ACK SHALL last one cycle and then go to IDLE; the write SHALL be committed at the ACK clock edge.
REQ-019 BUSY SHALL equal (RD or WR) and not ACK, combinationally; an access therefore completes exactly WAIT_CYCLES+1 cycles after the request rises.
REQ-020 DAT_O SHALL be registered and valid in ACK; outside ACK it SHALL be 0.
REQ-021 Map: 0x00 REV (RO, REV_ID); 0x01 scratch (RW); 0x02 command_config (RW, default 0); 0x03 mac_0 (RW); 0x04 mac_1 (RW, bits 15:0 only, upper bits read 0); 0x05 frm_length (RW, bits 15:0, default 1518).
REQ-022 Unmapped reads SHALL return 0; unmapped writes and writes to REV SHALL be ignored.
REQ-023 If RD and WR are both high, the access SHALL be serviced as a write and DAT_O SHALL be 0.
REQ-024 Writing command_config with bit 13 = 1 SHALL set SW_RESET; a counter SHALL then clear only bit 13 after SW_RESET_CYCLES cycles, and the other bits SHALL be retained.
REQ-025 A write to command_config while SW_RESET is set SHALL update bits other than 13 and SHALL NOT restart the counter.
REQ-026 Back-to-back requests SHALL be accepted in the cycle after ACK.

Reset
REQ-027 While reset is low: FSM = IDLE, counters = 0, DAT_O = 0, all registers at defaults, tx_ena = rx_ena = sw_reset_active = 0, mac_addr = 0.
REQ-028 Reset asserted mid-access SHALL abort the access with no register update.

Configuration
REQ-029 With MAC_RESP_STATS_EN defined: read-only 32-bit wrapping counters SHALL sit at 0x3A (completed reads) and 0x3B (completed writes), reset to 0, and aborted accesses SHALL NOT count.
REQ-030 Without MAC_RESP_STATS_EN: 0x3A and 0x3B SHALL behave as unmapped, and no counter logic SHALL exist.

Structure
REQ-031 Package mac_resp_pkg SHALL hold the register address constants, register defaults, the command_config bit indices and the FSM state enum.
REQ-032 One sub-module, mac_resp_regfile, SHALL hold register storage, decode and the SW_RESET counter; the top SHALL hold the FSM and BUSY generation.

Verification
REQ-033 Read 0x00 with WAIT_CYCLES = 2 -> BUSY high for 2 cycles, then DAT_O = 32'h0000_0901 with BUSY low in the third cycle.
REQ-034 Write 0x03 = 32'h1122_3344 and 0x04 = 32'hFFFF_5566 -> mac_addr = 48'h5566_1122_3344; reading 0x04 returns 32'h0000_5566.
REQ-035 Write 0x02 = 32'h0000_2003 -> sw_reset_active high for 4 cycles with tx_ena = rx_ena = 0, then bit 13 clears, tx_ena = rx_ena = 1, and reading 0x02 returns 32'h0000_0003.
REQ-036 Raise RD, drop it after 1 cycle of BUSY -> FSM returns to IDLE, no ACK; with MAC_RESP_STATS_EN defined, 0x3A is unchanged.
REQ-037 Drive RD and WR together to 0x01 with 32'hA5A5_A5A5 -> DAT_O = 0, and a subsequent read of 0x01 returns 32'hA5A5_A5A5.
REQ-038 Assert reset during WAIT of a write to 0x01 -> scratch stays 0 and BUSY = 0 immediately.
